// File: rtl/io_seq_monitor.sv
// Pad-bus sequence monitor: synchronises io_in and steps through a programmed
// table of masked patterns, reporting pass, strict-order failure or timeout.
module io_seq_monitor #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int TO_W  = 20,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] io_mask,
  input  logic             pat_we,
  input  logic [AW-1:0]    pat_addr,
  input  logic [WIDTH-1:0] pat_data,
  input  logic [AW:0]      pat_len,
  input  logic             start,
  input  logic             strict,
  input  logic [TO_W-1:0]  to_limit,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [AW:0]      match_idx,
  output logic [WIDTH-1:0] fail_value
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PASS, ST_FAIL} state_t;

  state_t           state;
  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] pat_tbl [DEPTH];
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  limit_l;
  logic [AW:0]      len_l;
  logic             strict_l;

  logic [AW-1:0]    cur_a, prev_a;
  logic [WIDTH-1:0] s2m;
  logic             hit_cur, hit_prev;
  logic [AW:0]      idx_inc;
  logic [TO_W-1:0]  cnt_inc;

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (&v) ? v : v + TO_W'(1);
  endfunction

  // Stage 1/2: two-flop synchroniser for the asynchronous pads
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= io_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) pat_tbl[i] <= '0;
    end else if (pat_we && !busy) begin
      pat_tbl[pat_addr] <= pat_data;
    end
  end

  // prev_a is only consulted when match_idx > 0, so its wrap at 0 is harmless
  assign cur_a    = match_idx[AW-1:0];
  assign prev_a   = cur_a - AW'(1);
  assign s2m      = s2 & io_mask;
  assign hit_cur  = (s2m == (pat_tbl[cur_a] & io_mask));
  assign hit_prev = (s2m == (pat_tbl[prev_a] & io_mask));
  assign idx_inc  = match_idx + (AW+1)'(1);
  assign cnt_inc  = sat_inc(to_cnt);

  // Stage 3: sequence FSM evaluating the synchronised sample
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      match_idx  <= '0;
      fail_value <= '0;
      to_cnt     <= '0;
      limit_l    <= '0;
      len_l      <= '0;
      strict_l   <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (hit_cur) begin
            match_idx <= idx_inc;
            to_cnt    <= '0;
            if (idx_inc == len_l) begin
              state <= ST_PASS;
              busy  <= 1'b0;
              pass  <= 1'b1;
            end
          end else if (strict_l && (match_idx != '0) && !hit_prev) begin
            state      <= ST_FAIL;
            busy       <= 1'b0;
            fail       <= 1'b1;
            fail_value <= s2;
          end else begin
            to_cnt <= cnt_inc;
            if ((limit_l != '0) && (cnt_inc == limit_l)) begin
              state      <= ST_FAIL;
              busy       <= 1'b0;
              fail       <= 1'b1;
              timeout    <= 1'b1;
              fail_value <= s2;
            end
          end
        end
        default: begin
          if (start) begin
            match_idx  <= '0;
            to_cnt     <= '0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            fail_value <= '0;
            strict_l   <= strict;
            len_l      <= pat_len;
            limit_l    <= to_limit;
            if (pat_len == '0) begin
              state <= ST_PASS;
              busy  <= 1'b0;
              pass  <= 1'b1;
            end else begin
              state <= ST_WAIT;
              busy  <= 1'b1;
              pass  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_seq_monitor.sv
// Scoreboard bench for io_seq_monitor: a stream-level reference model predicts
// each run's outcome and completion edge; a monitor compares on completion.
module tb_io_seq_monitor;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int TO_W  = 20;
  localparam int AW    = 4;

  logic             clock = 1'b0;
  logic             resetb;
  logic [WIDTH-1:0] io_in, io_mask, pat_data;
  logic             pat_we, start, strict;
  logic [AW-1:0]    pat_addr;
  logic [AW:0]      pat_len;
  logic [TO_W-1:0]  to_limit;
  logic             busy, pass, fail, timeout;
  logic [AW:0]      match_idx;
  logic [WIDTH-1:0] fail_value;

  always #5 clock = ~clock;

  io_seq_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TO_W(TO_W)) dut (
    .clock(clock), .resetb(resetb), .io_in(io_in), .io_mask(io_mask),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
    .pat_len(pat_len), .start(start), .strict(strict), .to_limit(to_limit),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .match_idx(match_idx), .fail_value(fail_value)
  );

  typedef struct {
    logic       p, f, t;
    int         idx;
    logic [7:0] fv;
    longint     edge_n;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  longint     cyc = 0;
  logic [1:0] mon_prev = 2'b00;
  logic [7:0] ref_tbl [DEPTH];
  bit         last_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: scan the sample stream the FSM will see, one sample per WAIT cycle
  function automatic void ref_run(input logic [7:0] v[$], input int len, input logic [7:0] mask,
                                  input bit st, input int tol, output int n, output bit done,
                                  output bit p, output bit f, output bit t, output int idx,
                                  output logic [7:0] fv);
    int cnt = 0;
    idx = 0; p = 0; f = 0; t = 0; fv = 8'h00; n = 0; done = 0;
    if (len == 0) begin p = 1; done = 1; return; end
    foreach (v[k]) begin
      n = k + 1;
      if ((v[k] & mask) == (ref_tbl[idx] & mask)) begin
        idx++;
        cnt = 0;
        if (idx == len) begin p = 1; done = 1; return; end
      end else if (st && idx > 0 && (v[k] & mask) != (ref_tbl[idx-1] & mask)) begin
        f = 1; fv = v[k]; done = 1; return;
      end else begin
        if (cnt < 2**TO_W - 1) cnt++;
        if (tol != 0 && cnt == tol) begin f = 1; t = 1; fv = v[k]; done = 1; return; end
      end
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if ({pass, fail} != 2'b00 && {pass, fail} != mon_prev) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("pass", pass, e.p);
          chk("fail", fail, e.f);
          chk("timeout", timeout, e.t);
          chk("match_idx", match_idx, e.idx);
          chk("fail_value", fail_value, e.fv);
          chk("busy_done", busy, 0);
          chk("done_edge", cyc, e.edge_n);
        end
      end
      mon_prev = {pass, fail};
    end
  end

  task automatic wr(input int a, input logic [7:0] d);
    pat_we = 1; pat_addr = AW'(a); pat_data = d;
    @(posedge clock); #1;
    pat_we = 0;
    ref_tbl[a] = d;
  endtask

  // Sample v[k] is applied two edges ahead of the FSM cycle that evaluates it
  task automatic do_run(input logic [7:0] v[$], input int len, input logic [7:0] mask,
                        input bit st, input int tol, input bit noise);
    int n, idx, w;
    bit done, p, f, t;
    logic [7:0] fv;
    exp_t e;
    ref_run(v, len, mask, st, tol, n, done, p, f, t, idx, fv);
    io_mask = mask;
    if (n > 0) io_in = v[0];
    @(posedge clock); #1;
    strict = st; to_limit = TO_W'(tol); pat_len = (AW+1)'(len); start = 1;
    if (n > 1) io_in = v[1];
    e.p = p; e.f = f; e.t = t; e.idx = idx; e.fv = fv; e.edge_n = cyc + 1 + n;
    sbq.push_back(e);
    last_pass = p;
    @(posedge clock); #1;
    start = 0;
    if (n > 0) chk("busy_wait", busy, 1);
    for (int k = 2; k < n; k++) begin
      io_in = v[k];
      if (noise) begin
        pat_we = 1; pat_addr = AW'($urandom); pat_data = 8'($urandom);
        start = ($urandom_range(3) == 0); pat_len = (AW+1)'($urandom);
        strict = 1'($urandom); to_limit = TO_W'($urandom_range(3));
      end
      @(posedge clock); #1;
    end
    pat_we = 0; start = 0;
    w = 0;
    while (sbq.size() != 0 && w < 8) begin
      @(negedge clock); #1;
      w++;
    end
    if (sbq.size() != 0) begin
      chk("run_completion", 0, 1);
      sbq.delete();
    end
  endtask

  task automatic rand_run();
    int len = $urandom_range(DEPTH, 0);
    logic [7:0] mask = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
    bit st = 1'($urandom);
    int tol = ($urandom_range(2) == 0) ? 0 : $urandom_range(12, 1);
    logic [7:0] v[$];
    int g = 0, n, idx;
    bit done, p, f, t;
    logic [7:0] fv;
    if (len == 0 && last_pass) len = 1;
    repeat ($urandom_range(4)) wr($urandom_range(DEPTH-1), 8'($urandom));
    for (int k = 0; k < len * 3 + 4; k++) begin
      int r = $urandom_range(9);
      if (r < 5 && g < len) begin v.push_back(ref_tbl[g]); g++; end
      else if (r < 7 && g > 0) v.push_back(ref_tbl[g-1]);
      else v.push_back(8'($urandom));
    end
    ref_run(v, len, mask, st, tol, n, done, p, f, t, idx, fv);
    while (!done) begin
      v.push_back(ref_tbl[idx]);
      ref_run(v, len, mask, st, tol, n, done, p, f, t, idx, fv);
    end
    do_run(v, len, mask, st, tol, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [7:0] v[$];
    logic [7:0] e0[$];
    resetb = 0; io_in = 0; io_mask = 8'hFF; pat_we = 0; pat_addr = 0; pat_data = 0;
    pat_len = 0; start = 0; strict = 0; to_limit = 0;
    for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_match_idx", match_idx, 0);
    resetb = 1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) wr(i, 8'(i + 1));
    wr(10, 8'hFF);
    wr(11, 8'h00);

    // Relaxed walk through the 12-entry table with junk in between
    v = {};
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(2)) v.push_back(8'($urandom));
      v.push_back(ref_tbl[i]);
    end
    do_run(v, 12, 8'hFF, 0, 0, 1);

    v = {}; v.push_back(8'h01); v.push_back(8'h02); v.push_back(8'h55);
    do_run(v, 12, 8'hFF, 1, 0, 0);

    do_run(e0, 0, 8'hFF, 0, 0, 0);

    v = {};
    repeat (102) v.push_back(8'h01);
    do_run(v, 12, 8'hFF, 0, 100, 1);

    wr(0, 8'h03);
    v = {}; v.push_back(8'hF3);
    do_run(v, 1, 8'h0F, 0, 0, 0);

    // Abort a sequence at match_idx=5 with reset
    wr(0, 8'h01);
    io_mask = 8'hFF; io_in = 8'h01;
    @(posedge clock); #1;
    strict = 0; to_limit = 0; pat_len = 12; start = 1;
    @(posedge clock); #1;
    start = 0;
    for (int k = 2; k <= 5; k++) begin
      io_in = 8'(k);
      @(posedge clock); #1;
    end
    for (int w = 0; w < 10 && match_idx != 5; w++) @(negedge clock);
    chk("idx_before_reset", match_idx, 5);
    #2 resetb = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_pass", pass, 0);
    chk("arst_fail", fail, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_match_idx", match_idx, 0);
    chk("arst_fail_value", fail_value, 0);
    for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 8'h00;
    last_pass = 0;
    @(posedge clock); #2;
    resetb = 1;
    @(negedge clock);

    v = {}; v.push_back(8'h00);
    do_run(v, 1, 8'hFF, 0, 0, 0);
    v = {}; v.push_back(8'h00); v.push_back(8'h07);
    do_run(v, 2, 8'hFF, 1, 0, 0);

    repeat (40) rand_run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_seq_monitor.md
IO_SEQ_MONITOR -- requirements
Module: io_seq_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: monitored pad-bus width.
REQ-002 SHALL have parameter DEPTH, default 16: expected-pattern table entries, power of two; AW = log2(DEPTH).
REQ-003 SHALL have parameter TO_W, default 20: timeout counter width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low. Ports: clock, input, 1, sole clock; resetb, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port io_in, input, WIDTH: pad values, asynchronous to clock.
REQ-006 SHALL have port io_mask, input, WIDTH: 1 = bit compared, 0 = don't-care.
REQ-007 SHALL have ports pat_we, input, 1; pat_addr, input, AW; pat_data, input, WIDTH: pattern-table write port.
REQ-008 SHALL have port pat_len, input, AW+1: number of patterns in the sequence, 0..DEPTH.
REQ-009 SHALL have ports start, input, 1; strict, input, 1; to_limit, input, TO_W.
REQ-010 SHALL have outputs busy, pass, fail, timeout, each 1 bit.
REQ-011 SHALL have outputs match_idx, AW+1: patterns matched so far; fail_value, WIDTH: synced sample captured at failure.

Function
REQ-012 SHALL pass io_in through a 2-flop synchronizer (s1, s2); all comparisons use s2.
REQ-013 SHALL write pat_data to table[pat_addr] on a clock edge with pat_we=1 and busy=0; writes while busy=1 are ignored.
REQ-014 SHALL implement the FSM states IDLE, WAIT, PASS and FAIL.
REQ-015 IDLE/PASS/FAIL with start=1: SHALL clear match_idx, timeout counter, pass, fail, timeout and fail_value, latch strict, pat_len and to_limit, then go to WAIT; if the latched pat_len=0, SHALL go directly to PASS.
REQ-016 SHALL ignore start while in WAIT.
REQ-017 WAIT, match defined as (s2 & io_mask) == (table[match_idx] & io_mask): SHALL increment match_idx by 1 and clear the timeout counter; at most one advance per cycle.
REQ-018 SHALL go WAIT -> PASS when the match of entry pat_len-1 occurs, with match_idx = pat_len.
REQ-019 Relaxed mode (strict=0): SHALL ignore non-matching samples.
REQ-020 Strict mode (strict=1), with match_idx>0: a sample equal (masked) to neither table[match_idx] nor table[match_idx-1] SHALL cause WAIT -> FAIL. If table[match_idx] equals table[match_idx-1], the FSM advances on the next cycle.
REQ-021 Timeout: SHALL increment the counter each WAIT cycle without an advance; when counter == to_limit and to_limit != 0, SHALL go to FAIL and set timeout=1. to_limit=0 disables the timeout. The counter saturates and never wraps.
REQ-022 On entry to FAIL, SHALL load fail_value with the s2 value of the failing cycle.
REQ-023 Priority in one cycle: match beats the strict-mismatch rule and beats timeout.
REQ-024 busy SHALL be 1 exactly in WAIT. pass is 1 in PASS; fail is 1 in FAIL. pass, fail, timeout, match_idx and fail_value SHALL hold until the next accepted start.
REQ-025 Latency: an io_in change settled before edge k SHALL be reflected in the registered outputs after edge k+2.

Reset
REQ-026 resetb=0 SHALL asynchronously force IDLE, clear s1/s2, match_idx, timeout counter, pass, fail, timeout, fail_value, busy and all table entries to 0, including mid-sequence; operation resumes only on a new start after release.

Verification
REQ-027 Load 01..0A,FF,00 (pat_len=12), mask FF, strict=0, to_limit=0, drive that sequence with arbitrary intermediate values -> pass=1, match_idx=12, fail=0.
REQ-028 Same table, strict=1, drive 01,02,55 -> fail=1, timeout=0, fail_value=55, match_idx=2.
REQ-029 to_limit=100, drive 01 then hold 01 -> fail=1, timeout=1 exactly 100 WAIT cycles after the advance; match_idx=1.
REQ-030 mask=0F, table entry 0=03, drive F3 -> advance; pat_len=0 with start -> pass=1 one cycle later; pat_we while busy -> table unchanged.
REQ-031 Assert resetb=0 at match_idx=5 -> all outputs 0 immediately, table reads 0; a new start with pat_len=1 and entry 00 passes with io_in=00.
REQ-032 io_in change timing: pass rises on the third rising edge after the final pattern appears; start pulsed during WAIT has no effect.
